signmag_conv_pipe: RTL and testbench
====================================

// Module: signmag_conv_pipe
// PURPOSE
//  Parametrised two's-complement to sign-magnitude converter, 2-stage pipelined, valid/ready on both sides.
//  Sits between the fixed-point datapath and the display/encode stages that consume sign + magnitude.
//  Most-negative input either saturates to max magnitude or is carried exactly (SAT_EN).
//  Counts saturation events for diagnostics.
// PARAMETERS
//  WIDTH   12  input word width (two's complement), >= 2
//  SAT_EN  1   1: most-negative -> magnitude 2^(WIDTH-1)-1, out_sat=1; 0: magnitude 2^(WIDTH-1) exact
//  CNT_W   8   width of saturation event counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       in_data valid
//  in_ready   out  1       block accepts in_data this cycle
//  in_data    in   WIDTH   two's-complement sample
//  out_valid  out  1       out_* valid
//  out_ready  in   1       consumer accepts output this cycle
//  out_sign   out  1       sign bit (1 = negative)
//  out_mag    out  WIDTH   magnitude; MSB is 0 unless SAT_EN=0 and input was most-negative
//  out_sat    out  1       this word was saturated
//  clr_cnt    in   1       synchronous clear of sat_cnt
//  sat_cnt    out  CNT_W   number of saturated words delivered, sticks at 2^CNT_W-1
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): s1/s2 valid=0, out_sign=0, out_mag=0, out_sat=0, sat_cnt=0.
//  Reset mid-operation: in-flight words discarded, never emitted.
//  Stage 1: register in_data, sign=in_data[WIDTH-1], flag is_min = sign & (in_data[WIDTH-2:0]==0).
//  Stage 2: sign=0 -> mag=data; sign=1 & !is_min -> mag=~data+1;
//   is_min & SAT_EN=1 -> mag={1'b0,{WIDTH-1{1'b1}}}, out_sat=1; is_min & SAT_EN=0 -> mag={1'b1,{WIDTH-1{1'b0}}}, out_sat=0.
//  Zero input: sign=0, mag=0. out_sign always equals input MSB (incl. saturated case).
//  Latency: 2 cycles from in_valid&in_ready to out_valid with no backpressure; throughput 1 word/cycle.
//  Handshake: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv.
//   in_ready is combinational from out_ready (no skid buffer). A word transfers on valid&ready.
//   While out_valid & !out_ready: out_* held stable, no word lost or duplicated, in_ready drops once s1 full.
//  Stage registers load only on their advance; data regs not cleared when bubble passes (valid gates use).
//  sat_cnt: +1 on out_valid & out_ready & out_sat; holds at all-ones; clr_cnt has priority over increment
//   (simultaneous clear and event -> 0).
//  No combinational path in_data -> out_*.
// STRUCTURE
//  Shared package: none required; macros for SAT_MAG/MIN_MAG patterns derived from WIDTH kept local.
//  One sub-module natural: signmag_core (combinational negate/saturate, WIDTH, SAT_EN) instanced in stage 2.
//  Pipeline control and sat_cnt in top level.
// TESTING
//  1 WIDTH=12,SAT_EN=1, out_ready=1: in 12'h005,12'hFFB,12'h000 back-to-back -> 2 cycles later
//    (0,005),(1,005),(0,000), one per cycle, out_sat=0.
//  2 in 12'h800 -> sign=1, mag=12'h7FF, out_sat=1, sat_cnt 0->1; SAT_EN=0 build: mag=12'h800, out_sat=0, cnt stays 0.
//  3 Backpressure: stream 8 words, out_ready low 3 cycles mid-stream -> out_* stable, in_ready low after
//    2 accepts, all 8 words emitted in order, none duplicated.
//  4 Reset asserted with both stages full -> out_valid=0, sat_cnt=0 immediately (async);
//    after release, first new word appears 2 cycles after accept.
//  5 CNT_W=2: 5 saturated words -> sat_cnt 1,2,3,3,3; clr_cnt same cycle as a saturated transfer -> 0.
//  6 Random stream vs reference model (WIDTH=4,12,16), random out_ready -> exact match, no loss.

Source files
------------

// File: rtl/signmag_conv_pipe_pkg.sv
// Shared types for the sign-magnitude converter: magnitude source selection
// used by the stage-2 datapath.
package signmag_conv_pipe_pkg;

  typedef enum logic [1:0] {
    MAG_PASS = 2'd0,
    MAG_NEG  = 2'd1,
    MAG_SAT  = 2'd2,
    MAG_MIN  = 2'd3
  } mag_sel_e;

  function automatic mag_sel_e mag_select(input logic sign, input logic is_min, input logic sat_en);
    mag_sel_e sel;
    if (!sign) begin
      sel = MAG_PASS;
    end else if (!is_min) begin
      sel = MAG_NEG;
    end else if (sat_en) begin
      sel = MAG_SAT;
    end else begin
      sel = MAG_MIN;
    end
    return sel;
  endfunction

endpackage

// File: rtl/signmag_conv_pipe_if.sv
// Valid/ready stream bundle for the converter: two's-complement words in,
// sign + magnitude + saturation flag out.
interface signmag_conv_pipe_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-1:0] out_mag;
  logic             out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_sat
  );
endinterface

// File: rtl/signmag_conv_pipe_core.sv
// Combinational negate/saturate: turns a registered two's-complement word plus
// its most-negative flag into a magnitude and saturation flag.
module signmag_conv_pipe_core
  import signmag_conv_pipe_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int SAT_EN = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             is_min,
  output logic [WIDTH-1:0] mag,
  output logic             sat
);
  localparam logic [WIDTH-1:0] SAT_MAG = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  mag_sel_e sel;

  assign sel = mag_select(data[WIDTH-1], is_min, SAT_EN != 0);

  always_comb begin
    mag = data;
    sat = 1'b0;
    case (sel)
      MAG_PASS: mag = data;
      MAG_NEG:  mag = ~data + ONE;
      MAG_SAT: begin
        mag = SAT_MAG;
        sat = 1'b1;
      end
      MAG_MIN:  mag = MIN_MAG;
      default:  mag = data;
    endcase
  end

endmodule

// File: rtl/signmag_conv_pipe.sv
// Two-stage valid/ready pipeline converting two's complement to sign-magnitude,
// with a sticky saturation-event counter on delivered words.
module signmag_conv_pipe
  import signmag_conv_pipe_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  signmag_conv_pipe_if.slave bus,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   sat_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_data_reg;
  logic             s1_is_min_reg;

  logic             s2_valid_reg;
  logic             s2_sign_reg;
  logic [WIDTH-1:0] s2_mag_reg;
  logic             s2_sat_reg;

  logic [CNT_W-1:0] sat_cnt_reg;
  logic [CNT_W-1:0] sat_cnt_next;

  logic             s1_adv;
  logic             s2_adv;
  logic             out_xfer;
  logic [WIDTH-1:0] core_mag;
  logic             core_sat;

  // in_ready is combinational from out_ready: no skid buffer in front of stage 1.
  assign s2_adv   = !s2_valid_reg || bus.out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign out_xfer = s2_valid_reg && bus.out_ready;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_reg;
  assign bus.out_sign  = s2_sign_reg;
  assign bus.out_mag   = s2_mag_reg;
  assign bus.out_sat   = s2_sat_reg;
  assign sat_cnt       = sat_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_data_reg   <= '0;
      s1_is_min_reg <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data_reg   <= bus.in_data;
        s1_is_min_reg <= bus.in_data[WIDTH-1] && (bus.in_data[WIDTH-2:0] == '0);
      end
    end
  end

  signmag_conv_pipe_core #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_core (
    .data   (s1_data_reg),
    .is_min (s1_is_min_reg),
    .mag    (core_mag),
    .sat    (core_sat)
  );

  // Payload only loads with a real word; a passing bubble leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_sign_reg  <= 1'b0;
      s2_mag_reg   <= '0;
      s2_sat_reg   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_sign_reg <= s1_data_reg[WIDTH-1];
        s2_mag_reg  <= core_mag;
        s2_sat_reg  <= core_sat;
      end
    end
  end

  always_comb begin
    sat_cnt_next = sat_cnt_reg;
    if (clr_cnt) begin
      sat_cnt_next = '0;
    end else if (out_xfer && s2_sat_reg && (sat_cnt_reg != CNT_MAX)) begin
      sat_cnt_next = sat_cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_reg <= '0;
    end else begin
      sat_cnt_reg <= sat_cnt_next;
    end
  end

endmodule

// File: tb/tb_signmag_conv_pipe.sv
// Bench for signmag_conv_pipe: directed table and corner sequences on 12-bit
// builds, plus randomized streams on three configurations against a model.
module tb_signmag_conv_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        rst_n;
  logic        d_in_valid;
  logic [11:0] d_in_data;
  logic        d_out_ready;
  logic        clr_cnt;
  logic        rand_go;

  logic [7:0]  cnt_a;
  logic [7:0]  cnt_b;
  logic [1:0]  cnt_c;

  signmag_conv_pipe_if #(.WIDTH(12)) ifa ();
  signmag_conv_pipe_if #(.WIDTH(12)) ifb ();
  signmag_conv_pipe_if #(.WIDTH(12)) ifc ();

  assign ifa.in_valid  = d_in_valid;
  assign ifa.in_data   = d_in_data;
  assign ifa.out_ready = d_out_ready;
  assign ifb.in_valid  = d_in_valid;
  assign ifb.in_data   = d_in_data;
  assign ifb.out_ready = d_out_ready;
  assign ifc.in_valid  = d_in_valid;
  assign ifc.in_data   = d_in_data;
  assign ifc.out_ready = d_out_ready;

  signmag_conv_pipe #(.WIDTH(12), .SAT_EN(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .clr_cnt(clr_cnt), .sat_cnt(cnt_a));
  signmag_conv_pipe #(.WIDTH(12), .SAT_EN(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .clr_cnt(clr_cnt), .sat_cnt(cnt_b));
  signmag_conv_pipe #(.WIDTH(12), .SAT_EN(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc), .clr_cnt(clr_cnt), .sat_cnt(cnt_c));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed value from the bit pattern, absolute value, clamp only the one unrepresentable case.
  function automatic logic [13:0] ref12(input logic [11:0] d, input bit sat_en);
    int v;
    int a;
    logic s;
    logic st;
    v  = d[11] ? int'(d) - 4096 : int'(d);
    s  = (v < 0);
    a  = s ? -v : v;
    st = 1'b0;
    if (sat_en && a == 2048) begin
      a  = 2047;
      st = 1'b1;
    end
    return {s, st, a[11:0]};
  endfunction

  typedef struct {
    logic [11:0] din;
    logic        sign;
    logic [11:0] mag_a;
    logic        sat_a;
    logic [11:0] mag_b;
  } vec_t;

  vec_t        tbl [8];
  logic [11:0] bp_words [8];
  logic [13:0] bp_q [$];
  logic [13:0] bp_exp;
  logic [13:0] held;
  bit          stalled;
  int          sent;
  int          recv;

  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int W  = (gi == 0) ? 4 : (gi == 1) ? 12 : 16;
    localparam int SE = (gi == 1) ? 0 : 1;
    localparam int CW = (gi == 2) ? 3 : 8;
    localparam int NW = 300;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    signmag_conv_pipe_if #(.WIDTH(W)) rif ();
    logic [CW-1:0] cnt;
    logic          clr;
    bit            done;

    signmag_conv_pipe #(.WIDTH(W), .SAT_EN(SE), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(rif), .clr_cnt(clr), .sat_cnt(cnt));

    function automatic logic [W+1:0] ref_conv(input logic [W-1:0] d);
      longint v;
      longint a;
      logic   s;
      logic   st;
      v = longint'(d);
      if (d[W-1]) v = v - (longint'(1) << W);
      s  = (v < 0);
      a  = s ? -v : v;
      st = 1'b0;
      if (SE != 0 && a == (longint'(1) << (W-1))) begin
        a  = a - 1;
        st = 1'b1;
      end
      return {s, st, a[W-1:0]};
    endfunction

    initial begin
      logic [W+1:0] q [$];
      logic [W+1:0] e;
      int           got;
      int           nsent;
      longint       mcnt;
      bit           acc;
      done = 1'b0;
      rif.in_valid  = 1'b0;
      rif.in_data   = '0;
      rif.out_ready = 1'b0;
      clr = 1'b0;
      got = 0;
      nsent = 0;
      mcnt = 0;
      acc = 1'b0;
      wait (rand_go);
      for (int cyc = 0; cyc < 4000 && got < NW; cyc++) begin
        @(posedge clk);
        #1;
        if (acc || !rif.in_valid) begin
          if (nsent < NW) begin
            rif.in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
              0:       rif.in_data = MOST_NEG;
              1:       rif.in_data = '0;
              default: rif.in_data = W'($urandom);
            endcase
          end else begin
            rif.in_valid = 1'b0;
          end
        end
        rif.out_ready = ($urandom_range(0, 2) != 0);
        clr = ($urandom_range(0, 49) == 0);
        @(negedge clk);
        chk($sformatf("rand_w%0d_cnt", W), 64'(cnt), 64'(mcnt));
        acc = rif.in_valid && rif.in_ready;
        if (acc) begin
          q.push_back(ref_conv(rif.in_data));
          nsent++;
        end
        if (rif.out_valid && rif.out_ready) begin
          if (q.size() == 0) begin
            chk($sformatf("rand_w%0d_extra_word", W), 64'(1), 64'(0));
            e = '0;
          end else begin
            e = q.pop_front();
          end
          chk($sformatf("rand_w%0d_word", W), 64'({rif.out_sign, rif.out_sat, rif.out_mag}), 64'(e));
          got++;
        end
        if (clr) begin
          mcnt = 0;
        end else if (rif.out_valid && rif.out_ready && rif.out_sat && mcnt < (longint'(1) << CW) - 1) begin
          mcnt = mcnt + 1;
        end
      end
      chk($sformatf("rand_w%0d_count", W), 64'(got), 64'(NW));
      done = 1'b1;
    end
  end

  initial begin
    tbl[0] = '{12'h005, 1'b0, 12'h005, 1'b0, 12'h005};
    tbl[1] = '{12'hFFB, 1'b1, 12'h005, 1'b0, 12'h005};
    tbl[2] = '{12'h000, 1'b0, 12'h000, 1'b0, 12'h000};
    tbl[3] = '{12'h800, 1'b1, 12'h7FF, 1'b1, 12'h800};
    tbl[4] = '{12'h7FF, 1'b0, 12'h7FF, 1'b0, 12'h7FF};
    tbl[5] = '{12'h801, 1'b1, 12'h7FF, 1'b0, 12'h7FF};
    tbl[6] = '{12'hFFF, 1'b1, 12'h001, 1'b0, 12'h001};
    tbl[7] = '{12'h001, 1'b0, 12'h001, 1'b0, 12'h001};
    bp_words = '{12'h123, 12'hF00, 12'h800, 12'h7FF, 12'h001, 12'hFFF, 12'h456, 12'hA5A};

    rst_n = 1'b0;
    d_in_valid = 1'b0;
    d_in_data = '0;
    d_out_ready = 1'b1;
    clr_cnt = 1'b0;
    rand_go = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(ifa.out_valid), 0);
    chk("reset_out_sign_mag_sat", 64'({ifa.out_sign, ifa.out_sat, ifa.out_mag}), 0);
    chk("reset_sat_cnt", 64'(cnt_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back table, two-cycle latency, SAT_EN=1 and SAT_EN=0 builds side by side
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      d_in_valid = (i < 8);
      d_in_data  = (i < 8) ? tbl[i].din : 12'h000;
      @(negedge clk);
      chk("tbl_in_ready", 64'(ifa.in_ready), 1);
      if (i < 2) begin
        chk("tbl_latency_idle", 64'(ifa.out_valid), 0);
      end else begin
        chk("tbl_out_valid", 64'(ifa.out_valid), 1);
        chk($sformatf("tbl_a_%03h", tbl[i-2].din), 64'({ifa.out_sign, ifa.out_sat, ifa.out_mag}),
            64'({tbl[i-2].sign, tbl[i-2].sat_a, tbl[i-2].mag_a}));
        chk($sformatf("tbl_b_%03h", tbl[i-2].din), 64'({ifb.out_sign, ifb.out_sat, ifb.out_mag}),
            64'({tbl[i-2].sign, 1'b0, tbl[i-2].mag_b}));
      end
    end
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    @(negedge clk);
    chk("tbl_drained", 64'(ifa.out_valid), 0);
    chk("tbl_sat_cnt_a", 64'(cnt_a), 1);
    chk("tbl_sat_cnt_b", 64'(cnt_b), 0);

    // Backpressure: 8 words, out_ready low for 3 cycles mid-stream
    sent = 0;
    recv = 0;
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      @(posedge clk);
      #1;
      d_in_valid  = (sent < 8);
      d_in_data   = (sent < 8) ? bp_words[sent] : 12'h000;
      d_out_ready = !(cyc >= 4 && cyc <= 6);
      @(negedge clk);
      if (stalled) begin
        chk("bp_hold_valid", 64'(ifa.out_valid), 1);
        chk("bp_hold_data", 64'({ifa.out_sign, ifa.out_sat, ifa.out_mag}), 64'(held));
      end
      if (cyc >= 4 && cyc <= 6) chk("bp_in_ready_low", 64'(ifa.in_ready), 0);
      if (d_in_valid && ifa.in_ready) begin
        bp_q.push_back(ref12(d_in_data, 1'b1));
        sent++;
      end
      if (ifa.out_valid && d_out_ready) begin
        if (bp_q.size() == 0) begin
          chk("bp_extra_word", 1, 0);
          bp_exp = '0;
        end else begin
          bp_exp = bp_q.pop_front();
        end
        chk("bp_word", 64'({ifa.out_sign, ifa.out_sat, ifa.out_mag}), 64'(bp_exp));
        recv++;
      end
      stalled = ifa.out_valid && !d_out_ready;
      held    = {ifa.out_sign, ifa.out_sat, ifa.out_mag};
    end
    chk("bp_words_received", 64'(recv), 8);
    @(posedge clk);
    #1;
    d_in_valid  = 1'b0;
    d_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_duplicate", 64'(ifa.out_valid), 0);
    chk("bp_sat_cnt_a", 64'(cnt_a), 2);
    chk("bp_sat_cnt_c", 64'(cnt_c), 2);

    // Counter: clear, then 5 saturated words into a 2-bit counter
    @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_cnt_a", 64'(cnt_a), 0);
    chk("clr_cnt_c", 64'(cnt_c), 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      d_in_valid = (i < 5);
      d_in_data  = 12'h800;
      @(negedge clk);
      if (i >= 3) chk($sformatf("cnt_c_after_%0d", i - 2), 64'(cnt_c), 64'((i - 2 > 3) ? 3 : i - 2));
    end
    chk("cnt_a_five", 64'(cnt_a), 5);

    // Clear coincident with a saturated transfer: clear wins
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      d_in_valid = (i == 0);
      d_in_data  = 12'h800;
      clr_cnt    = (i == 2);
      @(negedge clk);
      if (i == 2) chk("clr_race_sat_word", 64'({ifc.out_valid, ifc.out_sat}), 64'(2'b11));
      if (i == 3) begin
        chk("clr_race_cnt_c", 64'(cnt_c), 0);
        chk("clr_race_cnt_a", 64'(cnt_a), 0);
      end
    end

    // Async reset with both stages full
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      d_in_valid = (i == 0);
      d_in_data  = 12'h800;
      @(negedge clk);
    end
    chk("rst_pre_cnt", 64'(cnt_a), 1);
    d_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      d_in_valid = (i < 2);
      d_in_data  = (i == 0) ? 12'h111 : 12'h800;
      @(negedge clk);
    end
    chk("rst_pre_full", 64'({ifa.out_valid, ifa.in_ready}), 64'(2'b10));
    rst_n = 1'b0;
    d_in_valid = 1'b0;
    #1;
    chk("rst_async_valid", 64'(ifa.out_valid), 0);
    chk("rst_async_cnt", 64'(cnt_a), 0);
    chk("rst_async_mag", 64'(ifa.out_mag), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      d_in_valid = (i == 0);
      d_in_data  = 12'hFFB;
      @(negedge clk);
      if (i < 2) begin
        chk("rst_no_stale_word", 64'(ifa.out_valid), 0);
      end else begin
        chk("rst_first_word", 64'({ifa.out_valid, ifa.out_sign, ifa.out_sat, ifa.out_mag}),
            64'({1'b1, 1'b1, 1'b0, 12'h005}));
      end
    end
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;

    // Randomized streams on WIDTH=4/12/16
    rand_go = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (g_rand[0].done && g_rand[1].done && g_rand[2].done) break;
      @(posedge clk);
    end
    chk("rand_finished", 64'({g_rand[0].done, g_rand[1].done, g_rand[2].done}), 64'(3'b111));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
